cpu_mem_bus_arbiter: RTL

Shares the single external memory bus between the two cache-miss requesters of the core: port 0 is instruction fetch, port 1 is the commit stage. It grants the bus to one port at a time using round-robin order and forwards the granted port's read or write request to memory. It holds the bus until memory returns a response, routes that response back to the owning port, and recovers from a lost response with a watchdog.

---
 rtl/cpu_mem_bus_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/cpu_mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between instruction fetch (port 0)
// and commit (port 1); holds the bus until memory responds or the watchdog expires.
module cpu_mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            want_i,
  output logic [1:0]            available_o,
  input  logic [1:0]            read_i,
  input  logic [1:0]            write_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [LINE_WIDTH-1:0] data0_i,
  input  logic [LINE_WIDTH-1:0] data1_i,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_data_o,
  input  logic                  mem_valid_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  output logic [1:0]            resp_valid_o,
  output logic [ADDR_WIDTH-1:0] resp_addr_o,
  output logic [LINE_WIDTH-1:0] resp_data_o,
  output logic                  timeout_o
);

  localparam int TIMER_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state;
  logic                 owner;
  logic                 last;
  logic [TIMER_W-1:0]   timer;

  logic                 pick;
  logic                 own_rd;
  logic                 own_wr;
  logic                 expired;

  // A tie goes to the port that did not complete the previous transaction.
  always_comb begin
    pick = 1'b1;
    if (want_i[0]) pick = want_i[1] & ~last;
  end

  assign own_rd  = read_i[owner];
  assign own_wr  = write_i[owner];
  assign expired = (timer == TIMER_W'(TIMEOUT - 1));

  // Request forwarding; a simultaneous read and write is treated as a write.
  assign mem_read_o  = ~reset & (state == S_GRANT) & own_rd & ~own_wr;
  assign mem_write_o = ~reset & (state == S_GRANT) & own_wr;
  assign mem_addr_o  = owner ? addr1_i : addr0_i;
  assign mem_data_o  = owner ? data1_i : data0_i;

  // Response path: payload is always passed through, only the strobe qualifies it.
  assign resp_addr_o  = mem_addr_i;
  assign resp_data_o  = mem_data_i;
  assign resp_valid_o = (~reset && state == S_WAIT && mem_valid_i) ?
                        (owner ? 2'b10 : 2'b01) : 2'b00;
  assign timeout_o    = ~reset & (state == S_WAIT) & expired & ~mem_valid_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last        <= 1'b0;
      timer       <= '0;
      available_o <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (|want_i) begin
            owner       <= pick;
            available_o <= pick ? 2'b10 : 2'b01;
            state       <= S_GRANT;
          end
        end
        S_GRANT: begin
          available_o <= 2'b00;
          if (own_rd || own_wr) begin
            timer <= '0;
            state <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          timer <= timer + TIMER_W'(1);
          if (mem_valid_i || expired) begin
            last  <= owner;
            state <= S_IDLE;
          end
        end
        default: begin
          available_o <= 2'b00;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
